// File: rtl/counter_ctrl_if.sv
// counter_ctrl_if: switch commands in, step/direction/shadow-count status out
interface counter_ctrl_if #(
    parameter int VW = 4
);
    logic          start;
    logic          stop;
    logic          clear;
    logic          mode_up;
    logic [VW-1:0] preset;
    logic          step;
    logic          dir;
    logic          cnt_clr;
    logic [VW-1:0] value;
    logic [1:0]    state;
    logic          done;

    modport master (
        output start, stop, clear, mode_up, preset,
        input  step, dir, cnt_clr, value, state, done
    );

    modport slave (
        input  start, stop, clear, mode_up, preset,
        output step, dir, cnt_clr, value, state, done
    );
endinterface

// File: rtl/counter_ctrl.sv
// counter_ctrl: paces step pulses from switch commands and stops at a terminal count
module counter_ctrl #(
    parameter int TICK_DIV = 4,
    parameter int MAX_VAL  = 9,
    parameter int VW       = 4
) (
    input logic           clk_2,
    input logic           reset,
    counter_ctrl_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

    state_t        state_q;
    logic [VW-1:0] value_q, tgt_q, tgt_sat, val_nx;
    logic [PW-1:0] pre_q;
    logic          dir_q, step_q, clr_q, done_q;
    logic          start_q, stop_q, clear_q;
    logic          start_e, stop_e, clear_e, go, wrap, hit;

    // Command edges (stop outranks start), saturated target, next counter position
    always_comb begin
        start_e = bus.start & ~start_q;
        stop_e  = bus.stop & ~stop_q;
        clear_e = bus.clear & ~clear_q;
        go      = start_e & ~stop_e;
        tgt_sat = (bus.preset > VW'(MAX_VAL)) ? VW'(MAX_VAL) : bus.preset;
        wrap    = pre_q == PW'(TICK_DIV - 1);
        val_nx  = dir_q ? value_q + 1'b1 : value_q - 1'b1;
        hit     = val_nx == tgt_q;
    end

    // Run-control FSM with registered step/clear pulses and status
    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            value_q <= '0;
            tgt_q   <= '0;
            pre_q   <= '0;
            dir_q   <= 1'b1;
            step_q  <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b1;
            stop_q  <= 1'b1;
            clear_q <= 1'b1;
        end else begin
            start_q <= bus.start;
            stop_q  <= bus.stop;
            clear_q <= bus.clear;
            step_q  <= 1'b0;
            clr_q   <= 1'b0;
            if (clear_e) begin
                state_q <= IDLE;
                done_q  <= 1'b0;
                value_q <= '0;
                pre_q   <= '0;
                clr_q   <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: if (go) begin
                        dir_q   <= bus.mode_up;
                        tgt_q   <= bus.mode_up ? tgt_sat : '0;
                        value_q <= bus.mode_up ? '0 : tgt_sat;
                        pre_q   <= '0;
                        state_q <= (tgt_sat == '0) ? DONE : RUN;
                        done_q  <= tgt_sat == '0;
                    end
                    RUN, PAUSE: begin
                        if (state_q == RUN && stop_e) begin
                            state_q <= PAUSE;
                        end else if (state_q == RUN || go) begin
                            // resuming from PAUSE counts as a running cycle, so pause time adds exactly
                            if (wrap) begin
                                pre_q   <= '0;
                                step_q  <= 1'b1;
                                value_q <= val_nx;
                                state_q <= hit ? DONE : RUN;
                                done_q  <= hit;
                            end else begin
                                pre_q   <= pre_q + 1'b1;
                                state_q <= RUN;
                            end
                        end
                    end
                    DONE: ;
                    default: begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.step    = step_q;
    assign bus.dir     = dir_q;
    assign bus.cnt_clr = clr_q;
    assign bus.value   = value_q;
    assign bus.state   = state_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: table-driven and directed checks of counter_ctrl run control
module tb_counter_ctrl;
    logic clk_2 = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    counter_ctrl_if #(.VW(4)) bus ();

    counter_ctrl #(.TICK_DIV(4), .MAX_VAL(9), .VW(4)) dut (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk_2 = ~clk_2;

    typedef struct {
        logic       st, sp, cl, mu;
        logic [3:0] pre;
        int         n;
        logic       e_step, e_clr, e_dir, e_done;
        logic [3:0] e_val;
        logic [1:0] e_state;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic st, input logic sp, input logic cl, input logic mu,
                                input logic [3:0] pre, input int n,
                                input logic e_step, input logic e_clr, input logic e_dir,
                                input logic e_done, input logic [3:0] e_val, input logic [1:0] e_state);
        vec_t v;
        v.st = st; v.sp = sp; v.cl = cl; v.mu = mu; v.pre = pre; v.n = n;
        v.e_step = e_step; v.e_clr = e_clr; v.e_dir = e_dir; v.e_done = e_done;
        v.e_val = e_val; v.e_state = e_state;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_2);
        #1;
    endtask

    task automatic drive(input logic st, input logic sp, input logic cl, input logic mu, input logic [3:0] pre);
        bus.start = st; bus.stop = sp; bus.clear = cl; bus.mode_up = mu; bus.preset = pre;
    endtask

    task automatic chk_all(input string tag, input logic e_step, input logic e_clr, input logic e_dir,
                           input logic e_done, input logic [3:0] e_val, input logic [1:0] e_state);
        chk({tag, ".step"}, 32'(bus.step), 32'(e_step));
        chk({tag, ".cnt_clr"}, 32'(bus.cnt_clr), 32'(e_clr));
        chk({tag, ".dir"}, 32'(bus.dir), 32'(e_dir));
        chk({tag, ".done"}, 32'(bus.done), 32'(e_done));
        chk({tag, ".value"}, 32'(bus.value), 32'(e_val));
        chk({tag, ".state"}, 32'(bus.state), 32'(e_state));
    endtask

    initial begin
        int stray;
        // up to 3: steps after k+4, k+8, k+12, then DONE and quiet
        add(1,0,0,1,4'd3,1,  0,0,1,0,4'd0,2'd1);
        add(0,0,0,1,4'd3,3,  0,0,1,0,4'd0,2'd1);
        add(0,0,0,1,4'd3,1,  1,0,1,0,4'd1,2'd1);
        add(0,0,0,1,4'd3,3,  0,0,1,0,4'd1,2'd1);
        add(0,0,0,1,4'd3,1,  1,0,1,0,4'd2,2'd1);
        add(0,0,0,1,4'd3,4,  1,0,1,1,4'd3,2'd3);
        add(0,0,0,1,4'd3,40, 0,0,1,1,4'd3,2'd3);
        add(0,0,1,1,4'd3,1,  0,1,1,0,4'd0,2'd0);
        add(0,0,0,1,4'd3,1,  0,0,1,0,4'd0,2'd0);
        // down from saturated 12 -> 9, nine steps to 0
        add(1,0,0,0,4'd12,1, 0,0,0,0,4'd9,2'd1);
        for (int i = 1; i <= 9; i++)
            add(0,0,0,0,4'd12,4, 1,0,0,(i == 9),4'(9 - i),(i == 9) ? 2'd3 : 2'd1);
        add(0,0,1,0,4'd12,1, 0,1,0,0,4'd0,2'd0);
        add(0,0,0,0,4'd12,1, 0,0,0,0,4'd0,2'd0);
        // preset 0: straight to DONE, start/stop ignored, clear leaves
        add(1,0,0,1,4'd0,1,  0,0,1,1,4'd0,2'd3);
        add(0,0,0,1,4'd0,1,  0,0,1,1,4'd0,2'd3);
        add(1,1,0,1,4'd0,1,  0,0,1,1,4'd0,2'd3);
        add(0,0,0,1,4'd0,3,  0,0,1,1,4'd0,2'd3);
        add(0,0,1,1,4'd0,1,  0,1,1,0,4'd0,2'd0);
        add(0,0,0,1,4'd0,1,  0,0,1,0,4'd0,2'd0);

        drive(0,0,0,0,4'd0);
        repeat (3) @(posedge clk_2);
        #1 reset = 1'b1;
        chk_all("reset", 0,0,1,0,4'd0,2'd0);
        cyc();
        chk_all("post_reset", 0,0,1,0,4'd0,2'd0);

        foreach (vecs[r]) begin
            drive(vecs[r].st, vecs[r].sp, vecs[r].cl, vecs[r].mu, vecs[r].pre);
            stray = 0;
            for (int c = 0; c < vecs[r].n; c++) begin
                cyc();
                if (c < vecs[r].n - 1 && (bus.step || bus.cnt_clr)) stray++;
            end
            if (vecs[r].n > 1) chk($sformatf("row%0d.stray", r), 32'(stray), 0);
            chk_all($sformatf("row%0d", r), vecs[r].e_step, vecs[r].e_clr, vecs[r].e_dir,
                    vecs[r].e_done, vecs[r].e_val, vecs[r].e_state);
        end

        // pause after first step, second stop ignored, resume keeps the held offset
        drive(1,0,0,1,4'd5);
        cyc();
        bus.start = 0;
        repeat (4) cyc();
        chk_all("p_step1", 1,0,1,0,4'd1,2'd1);
        bus.stop = 1;
        cyc();
        bus.stop = 0;
        chk_all("p_enter", 0,0,1,0,4'd1,2'd2);
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            bus.stop = (i == 10);
            cyc();
            if (bus.step || bus.state != 2'd2) stray++;
        end
        bus.stop = 0;
        chk("p_hold", 32'(stray), 0);
        bus.start = 1;
        cyc();
        bus.start = 0;
        chk_all("p_resume", 0,0,1,0,4'd1,2'd1);
        stray = 0;
        repeat (2) begin
            cyc();
            if (bus.step) stray++;
        end
        chk("p_gap", 32'(stray), 0);
        cyc();
        chk_all("p_step2", 1,0,1,0,4'd2,2'd1);

        // clear and start together in RUN: clear wins, single cnt_clr, no step
        bus.clear = 1; bus.start = 1;
        cyc();
        bus.clear = 0; bus.start = 0;
        chk_all("cs", 0,1,1,0,4'd0,2'd0);
        stray = 0;
        repeat (6) begin
            cyc();
            if (bus.step || bus.cnt_clr || bus.state != 2'd0) stray++;
        end
        chk("cs_quiet", 32'(stray), 0);

        // asynchronous reset mid-RUN in down mode, switch held high across release
        drive(1,0,0,0,4'd9);
        cyc();
        bus.start = 0;
        repeat (5) cyc();
        chk_all("ar_run", 0,0,0,0,4'd8,2'd1);
        bus.start = 1;
        reset = 0;
        #1;
        chk_all("ar_now", 0,0,1,0,4'd0,2'd0);
        repeat (2) cyc();
        reset = 1;
        repeat (3) cyc();
        chk_all("ar_release", 0,0,1,0,4'd0,2'd0);
        bus.start = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Run-control sequencer for the board's single-digit up/down counter path. It turns switch-level start, stop and clear commands into a paced stream of one-cycle step pulses plus a direction bit, and stops automatically at a terminal value. It keeps a shadow count that feeds the seven-segment decoder and the LCD debug fields, and it flags completion on an LED.

## Interface
- TICK_DIV, 4: clock cycles between successive step pulses while running; must be ≥ 2.
- MAX_VAL, 9: largest legal count value; presets above it saturate to it.
- VW, 4: width of the count and preset fields.
- clk_2  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low (0 = reset); one clock domain only.
- start  in  1  level from a switch; only its 0→1 edge acts.
- stop  in  1  level from a switch; only its 0→1 edge acts.
- clear  in  1  level from a switch; only its 0→1 edge acts.
- mode_up  in  1  1 = count up, 0 = count down; sampled only on an accepted start from IDLE.
- preset  in  VW  terminal value (up mode) or start value (down mode); sampled only on an accepted start from IDLE.
- step  out  1  one-cycle pulse; the counter advances one position.
- dir  out  1  latched direction; 1 = up.
- cnt_clr  out  1  one-cycle pulse; zeroes the counter.
- value  out  VW  shadow count.
- state  out  2  IDLE = 0, RUN = 1, PAUSE = 2, DONE = 3.
- done  out  1  high exactly while state = DONE.

## Operation
- Edge detection: registered copies start_q, stop_q and clear_q. An edge is `in & ~in_q` at a clock edge. Priority is clear > stop > start; at most one command is accepted per cycle.
- tgt_sat = min(preset, MAX_VAL).
- Target: tgt = tgt_sat in up mode, 0 in down mode.
- clear, from any state: go to IDLE, set value = 0, set prescaler = 0, pulse cnt_clr for one cycle.
- IDLE + start: latch dir = mode_up and tgt. Load value = 0 (up) or tgt_sat (down). Set prescaler = 0 and go to RUN. If the loaded value already equals tgt, go to DONE instead and emit no step.
- RUN: prescaler counts 0 … TICK_DIV-1 and wraps.
  - When it wraps, pulse step and move value by ±1 in the latched direction.
  - If the new value equals tgt, go to DONE in the same edge.
  - value never leaves the range 0…MAX_VAL.
- RUN + stop: go to PAUSE. The prescaler holds its count and no step is emitted.
- PAUSE + start: go to RUN; the prescaler resumes from its held count.
- PAUSE + stop: ignored.
- DONE: step stays 0. Only clear leaves DONE; start and stop are ignored.
- In RUN and PAUSE, start is ignored. Changes on mode_up and preset are also ignored.
- Unused state encodings recover to IDLE on the next edge.

## Timing
- Reset values:
  - state = IDLE, value = 0, dir = 1, tgt = 0, prescaler = 0
  - step = 0, cnt_clr = 0, done = 0
  - start_q = 1, stop_q = 1, clear_q = 1, so a switch already high at reset release causes no command.
- All outputs are registered. A command sampled at edge k is visible on the outputs after edge k.
- Step pacing:
  - The start edge is accepted at edge k.
  - step is high for exactly one cycle after edges k+TICK_DIV, k+2·TICK_DIV, and so on.
  - value updates on the same edge that raises step.
- The final step and the transition to DONE are visible after the same edge.
- Pause and resume:
  - The time in PAUSE is added to the step interval.
  - Steps already taken are not repeated.
- cnt_clr is high for one cycle after the clear edge and is never high together with step.
- Reset asserted mid-operation forces all reset values asynchronously, with no pulse in flight.

## Test plan
- Hold reset = 0 for 3 cycles, then release with all switches low → state = 0, value = 0, step = 0, cnt_clr = 0, done = 0, dir = 1.
- Set mode_up = 1, preset = 3, raise start at edge k → step high after k+4, k+8, k+12. value goes 0→1→2→3, and state = 3 with done = 1 after k+12. No further steps in 40 cycles.
- Set mode_up = 0, preset = 12, then start → value is loaded as 9 (saturated) and dir = 0. Nine steps bring it to 0, 4 cycles apart, then done = 1.
- Up mode, preset = 5: after the first step, raise stop → state = 2 with no steps for 20 cycles. Raise start → the next step arrives at the held prescaler offset, and value continues from 1.
- In RUN with value = 2, raise clear and start in the same cycle → state = 0, value = 0, a single cnt_clr pulse, and no step. Then drive reset low mid-RUN → all reset values take effect immediately.
- Up mode, preset = 0, start → state = 3 after one edge with no step pulse. Raise start and stop in DONE → no change. Raise clear → IDLE.
